// File: rtl/access_ctrl_regfile.sv
// Register file with per-register owner policy and lockout after repeated denials.
// The admin identifier programs owners and is the only issuer that can unlock.
module access_ctrl_regfile #(
    parameter int              DATA_W    = 8,
    parameter int              ID_W      = 3,
    parameter int              NUM_REGS  = 4,
    parameter logic [ID_W-1:0] ADMIN_ID  = ID_W'(4),
    parameter int              MAX_FAILS = 3,
    localparam int             ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ID_W-1:0]   req_id,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              cfg_valid,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [ID_W-1:0]   cfg_allow_id,
    input  logic              cfg_unlock,
    output logic              rsp_valid,
    output logic              rsp_ok,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              locked
);

    localparam int CNT_W = $clog2(MAX_FAILS + 1);

    typedef enum logic {
        OPEN,
        LOCKED
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   fail_cnt;
    logic [CNT_W-1:0]   fail_nxt;
    logic [DATA_W-1:0]  regs   [NUM_REGS];
    logic [ID_W-1:0]    policy [NUM_REGS];

    logic id_hit;
    logic grant;
    logic cfg_admin;

    assign locked    = (state == LOCKED);
    assign id_hit    = (req_id == policy[req_addr]) || (req_id == ADMIN_ID);
    assign grant     = req_valid && (state == OPEN) && id_hit;
    assign cfg_admin = cfg_valid && (cfg_id == ADMIN_ID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]   <= '0;
                policy[i] <= ADMIN_ID;
            end
        end else begin
            if (grant && req_we) begin
                regs[req_addr] <= req_wdata;
            end
            if (cfg_admin && !cfg_unlock) begin
                policy[cfg_addr] <= cfg_allow_id;
            end
        end
    end

    // Read data is the pre-write value; denied or write responses carry zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_ok    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= req_valid;
            rsp_ok    <= grant;
            rsp_rdata <= (grant && !req_we) ? regs[req_addr] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OPEN;
            fail_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fail_cnt <= fail_nxt;
        end
    end

    // An admin unlock overrides whatever the same-cycle request would do.
    always_comb begin
        state_nxt = state;
        fail_nxt  = fail_cnt;
        if (req_valid && state == OPEN) begin
            if (grant) begin
                fail_nxt = '0;
            end else if (fail_cnt == CNT_W'(MAX_FAILS - 1)) begin
                fail_nxt  = CNT_W'(MAX_FAILS);
                state_nxt = LOCKED;
            end else begin
                fail_nxt = fail_cnt + 1'b1;
            end
        end
        if (cfg_admin && cfg_unlock) begin
            state_nxt = OPEN;
            fail_nxt  = '0;
        end
    end

endmodule

// File: tb/tb_access_ctrl_regfile.sv
// Directed bench for access_ctrl_regfile with hand-computed expectations.
module tb_access_ctrl_regfile;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_we;
    logic [1:0] req_addr;
    logic [2:0] req_id;
    logic [7:0] req_wdata;
    logic       cfg_valid;
    logic [2:0] cfg_id;
    logic [1:0] cfg_addr;
    logic [2:0] cfg_allow_id;
    logic       cfg_unlock;
    logic       rsp_valid;
    logic       rsp_ok;
    logic [7:0] rsp_rdata;
    logic       locked;

    int checks   = 0;
    int failures = 0;

    access_ctrl_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_id      (req_id),
        .req_wdata   (req_wdata),
        .cfg_valid   (cfg_valid),
        .cfg_id      (cfg_id),
        .cfg_addr    (cfg_addr),
        .cfg_allow_id(cfg_allow_id),
        .cfg_unlock  (cfg_unlock),
        .rsp_valid   (rsp_valid),
        .rsp_ok      (rsp_ok),
        .rsp_rdata   (rsp_rdata),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_id       = '0;
        req_wdata    = '0;
        cfg_valid    = 1'b0;
        cfg_id       = '0;
        cfg_addr     = '0;
        cfg_allow_id = '0;
        cfg_unlock   = 1'b0;
    endtask

    task automatic req(input logic we, input logic [1:0] a,
                       input logic [2:0] id, input logic [7:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_id    = id;
        req_wdata = d;
    endtask

    task automatic cfg(input logic [2:0] id, input logic [1:0] a,
                       input logic [2:0] allow, input logic unlock);
        cfg_valid    = 1'b1;
        cfg_id       = id;
        cfg_addr     = a;
        cfg_allow_id = allow;
        cfg_unlock   = unlock;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input string tag, input logic ok,
                       input logic [7:0] rd);
        chk({tag, "_v"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_ok"}, 32'(rsp_ok), 32'(ok));
        chk({tag, "_rd"}, 32'(rsp_rdata), 32'(rd));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ok", 32'(rsp_ok), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_valid", 32'(rsp_valid), 32'd0);

        // admin write then read back
        req(1'b1, 2'd1, 3'h4, 8'hA5); step(); idle();
        rsp("adm_wr", 1'b1, 8'h00);
        req(1'b0, 2'd1, 3'h4, 8'h00); step(); idle();
        rsp("adm_rd", 1'b1, 8'hA5);
        step();
        chk("idle_valid", 32'(rsp_valid), 32'd0);

        // same-cycle policy change does not apply to that request
        cfg(3'h4, 2'd2, 3'h1, 1'b0);
        req(1'b1, 2'd2, 3'h1, 8'h3C); step(); idle();
        rsp("old_pol", 1'b0, 8'h00);
        req(1'b1, 2'd2, 3'h1, 8'h3C); step(); idle();
        rsp("new_pol", 1'b1, 8'h00);
        req(1'b0, 2'd2, 3'h1, 8'h00); step(); idle();
        rsp("own_rd", 1'b1, 8'h3C);

        // non-admin cfg is ignored
        cfg(3'h2, 2'd3, 3'h2, 1'b0); step(); idle();
        req(1'b1, 2'd3, 3'h2, 8'h99); step(); idle();
        rsp("bad_cfg", 1'b0, 8'h00);
        req(1'b0, 2'd3, 3'h4, 8'h00); step(); idle();
        rsp("r3_clean", 1'b1, 8'h00);

        // grant clears the failure counter
        req(1'b1, 2'd0, 3'h2, 8'h11); step();
        req(1'b1, 2'd0, 3'h2, 8'h11); step();
        req(1'b0, 2'd0, 3'h4, 8'h00); step();
        rsp("mid_grant", 1'b1, 8'h00);
        req(1'b1, 2'd0, 3'h2, 8'h11); step();
        req(1'b1, 2'd0, 3'h2, 8'h11); step(); idle();
        chk("no_lock", 32'(locked), 32'd0);
        req(1'b1, 2'd0, 3'h4, 8'h5A); step(); idle();
        rsp("clr_wr", 1'b1, 8'h00);

        // three denials lock, admin then denied too
        req(1'b1, 2'd0, 3'h2, 8'hFF); step();
        req(1'b1, 2'd0, 3'h2, 8'hFF); step();
        chk("lock_pre", 32'(locked), 32'd0);
        req(1'b1, 2'd0, 3'h2, 8'hFF); step(); idle();
        chk("lock_3rd", 32'(locked), 32'd1);
        req(1'b1, 2'd0, 3'h4, 8'h77); step(); idle();
        rsp("lk_admin", 1'b0, 8'h00);
        chk("lk_hold", 32'(locked), 32'd1);

        // policy accepted while locked; only admin unlocks
        cfg(3'h4, 2'd0, 3'h2, 1'b0); step(); idle();
        cfg(3'h2, 2'd0, 3'h0, 1'b1); step(); idle();
        chk("bad_unlock", 32'(locked), 32'd1);
        cfg(3'h4, 2'd0, 3'h0, 1'b1); step(); idle();
        chk("unlock", 32'(locked), 32'd0);
        req(1'b0, 2'd0, 3'h4, 8'h00); step(); idle();
        rsp("r0_kept", 1'b1, 8'h5A);
        req(1'b1, 2'd0, 3'h2, 8'h66); step(); idle();
        rsp("lk_pol_wr", 1'b1, 8'h00);
        req(1'b0, 2'd0, 3'h2, 8'h00); step(); idle();
        rsp("lk_pol_rd", 1'b1, 8'h66);

        // unlock wins over a same-cycle locking denial
        req(1'b1, 2'd1, 3'h3, 8'h00); step();
        req(1'b1, 2'd1, 3'h3, 8'h00); step();
        cfg(3'h4, 2'd0, 3'h0, 1'b1);
        req(1'b1, 2'd1, 3'h3, 8'h00); step(); idle();
        chk("prio_open", 32'(locked), 32'd0);
        rsp("prio_rsp", 1'b0, 8'h00);
        req(1'b1, 2'd1, 3'h3, 8'h00); step();
        req(1'b1, 2'd1, 3'h3, 8'h00); step(); idle();
        chk("prio_cnt0", 32'(locked), 32'd0);
        req(1'b1, 2'd1, 3'h3, 8'h00); step(); idle();
        chk("prio_lock", 32'(locked), 32'd1);
        cfg(3'h4, 2'd0, 3'h0, 1'b1); step(); idle();
        chk("prio_unl", 32'(locked), 32'd0);

        // reset right after a granted read
        req(1'b0, 2'd0, 3'h4, 8'h00); step(); idle();
        rsp("pre_rst", 1'b1, 8'h66);
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(rsp_valid), 32'd0);
        chk("ar_ok", 32'(rsp_ok), 32'd0);
        chk("ar_rdata", 32'(rsp_rdata), 32'd0);
        chk("ar_locked", 32'(locked), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("ar_idle", 32'(rsp_valid), 32'd0);
        req(1'b0, 2'd0, 3'h2, 8'h00); step(); idle();
        rsp("ar_pol0", 1'b0, 8'h00);
        req(1'b0, 2'd2, 3'h1, 8'h00); step(); idle();
        rsp("ar_pol2", 1'b0, 8'h00);
        req(1'b0, 2'd0, 3'h4, 8'h00); step(); idle();
        rsp("ar_reg0", 1'b1, 8'h00);
        req(1'b0, 2'd1, 3'h4, 8'h00); step(); idle();
        rsp("ar_reg1", 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
